// File: rtl/lc3_pkg.sv
`default_nettype none
// =============================================================================
// lc3_pkg : LC-3 device-page address map and memory-controller FSM state type
// Rev 1.0
// =============================================================================
package lc3_pkg;

   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;
   localparam logic [15:0] ADDR_MCR  = 16'hFFFE;
   localparam logic [15:0] USER_LO   = 16'h3000;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      MEM_RD = 3'd1,
      MEM_WR = 3'd2,
      IO     = 3'd3,
      DONE   = 3'd4
   } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/lc3_mmio_regs.sv
`default_nettype none
// =============================================================================
// lc3_mmio_regs : KBSR/KBDR/DDR/MCR storage, keyboard/display handshakes, read mux
// Rev 1.0
// =============================================================================
module lc3_mmio_regs
   import lc3_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        acc,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_data,
   output logic [7:0]  disp_data,
   output logic        disp_valid,
   input  logic        disp_ready,
   output logic        halt
);

   logic        r_kbsr;
   logic [7:0]  r_kbdr;
   logic [15:0] r_mcr;
   logic        w_kbdr_rd;
   logic        w_ddr_wr;
   logic        w_mcr_wr;

   assign w_kbdr_rd = acc && !we && (addr == ADDR_KBDR);
   assign w_ddr_wr  = acc &&  we && (addr == ADDR_DDR);
   assign w_mcr_wr  = acc &&  we && (addr == ADDR_MCR);
   assign halt      = ~r_mcr[15];

   // A character arriving on the same edge as the KBDR-read clear is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_kbsr <= 1'b0;
         r_kbdr <= 8'h00;
      end else if (kbd_valid && (!r_kbsr || w_kbdr_rd)) begin
         r_kbsr <= 1'b1;
         r_kbdr <= kbd_data;
      end else if (w_kbdr_rd) begin
         r_kbsr <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_valid <= 1'b0;
         disp_data  <= 8'h00;
      end else if (w_ddr_wr) begin
         disp_valid <= 1'b1;
         disp_data  <= wdata[7:0];
      end else if (disp_valid && disp_ready) begin
         disp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcr <= 16'h8000;
      end else if (w_mcr_wr) begin
         r_mcr <= wdata;
      end
   end

   always_comb begin
      rdata = 16'h0000;
      case (addr)
         ADDR_KBSR: rdata = {r_kbsr, 15'b0};
         ADDR_KBDR: rdata = {8'h00, r_kbdr};
         ADDR_DSR:  rdata = {disp_ready & ~disp_valid, 15'b0};
         ADDR_MCR:  rdata = r_mcr;
         default:   rdata = 16'h0000;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// =============================================================================
// mem_ctrl : LC-3 MAR/MDR memory controller with req/done handshake and MMIO page
// Optional macro MEM_ACV_EN adds user-mode access violation (acv port).  Rev 1.0
// =============================================================================
module mem_ctrl
   import lc3_pkg::*;
#(
   parameter int          READ_LAT  = 1,
   parameter logic [15:0] MMIO_BASE = 16'hFE00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic        priv,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        done,
`ifdef MEM_ACV_EN
   output logic        acv,
`endif
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_data,
   output logic [7:0]  disp_data,
   output logic        disp_valid,
   input  logic        disp_ready,
   output logic        halt
);

   localparam logic [1:0] c_rd_last = 2'(READ_LAT - 1);

   mem_state_t  r_state;
   mem_state_t  w_next;
   logic [15:0] r_mar;
   logic [15:0] r_mdr_w;
   logic        r_we;
   logic [1:0]  r_cnt;
   logic        w_accept;
   logic        w_acv_hit;
   logic        w_rd_last;
   logic        w_io_acc;
   logic [15:0] w_io_rdata;

`ifdef MEM_ACV_EN
   logic r_acv;
   assign w_acv_hit = priv && ((addr < USER_LO) || (addr >= MMIO_BASE));
   assign acv       = r_acv;
`else
   logic w_unused_priv;
   assign w_acv_hit     = 1'b0;
   assign w_unused_priv = priv;
`endif

   assign w_accept  = (r_state == IDLE) && req;
   assign w_rd_last = (r_state == MEM_RD) && (r_cnt == c_rd_last);
   assign w_io_acc  = (r_state == IO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (req) begin
               if (w_acv_hit)              w_next = DONE;
               else if (addr >= MMIO_BASE) w_next = IO;
               else if (we)                w_next = MEM_WR;
               else                        w_next = MEM_RD;
            end
         end
         MEM_RD:  if (r_cnt == c_rd_last) w_next = DONE;
         MEM_WR:  w_next = DONE;
         IO:      w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Memory-side outputs are registered so an async reset silences them at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mar     <= 16'h0000;
         r_mdr_w   <= 16'h0000;
         r_we      <= 1'b0;
         r_cnt     <= 2'd0;
         rdata     <= 16'h0000;
         done      <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 16'h0000;
         mem_wdata <= 16'h0000;
`ifdef MEM_ACV_EN
         r_acv     <= 1'b0;
`endif
      end else begin
         done   <= (w_next == DONE);
         mem_we <= w_accept && (w_next == MEM_WR);
         r_cnt  <= (r_state == MEM_RD) ? r_cnt + 2'd1 : 2'd0;
`ifdef MEM_ACV_EN
         r_acv  <= w_accept && w_acv_hit;
`endif
         if (w_accept) begin
            r_mar   <= addr;
            r_mdr_w <= wdata;
            r_we    <= we;
         end
         if (w_accept && ((w_next == MEM_WR) || (w_next == MEM_RD))) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
         end
         if (w_rd_last)            rdata <= mem_rdata;
         if (w_io_acc && !r_we)    rdata <= w_io_rdata;
      end
   end

   lc3_mmio_regs u_mmio (
      .clk        (clk),
      .rst_n      (rst_n),
      .acc        (w_io_acc),
      .we         (r_we),
      .addr       (r_mar),
      .wdata      (r_mdr_w),
      .rdata      (w_io_rdata),
      .kbd_valid  (kbd_valid),
      .kbd_data   (kbd_data),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .disp_ready (disp_ready),
      .halt       (halt)
   );

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// =============================================================================
// tb_mem_ctrl : randomized bench for mem_ctrl against a transaction-level model
// Rev 1.0
// =============================================================================
module tb_mem_ctrl;

   localparam int          READ_LAT  = 1;
   localparam logic [15:0] MMIO_BASE = 16'hFE00;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0, priv = 1'b0;
   logic [15:0] addr = 16'h0, wdata = 16'h0;
   logic [15:0] rdata;
   logic        done, acv;
   logic        mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        kbd_valid = 1'b0;
   logic [7:0]  kbd_data = 8'h0;
   logic [7:0]  disp_data;
   logic        disp_valid;
   logic        disp_ready = 1'b0;
   logic        halt;

   int n_checks = 0;
   int n_pass   = 0;

   // memory block model and transaction-level reference state
   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] last_rd;
   bit          kb_full;
   logic [7:0]  kb_char;

   always #5 clk = ~clk;

   mem_ctrl #(.READ_LAT(READ_LAT), .MMIO_BASE(MMIO_BASE)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .priv(priv),
      .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
`ifdef MEM_ACV_EN
      .acv(acv),
`endif
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
      .disp_data(disp_data), .disp_valid(disp_valid), .disp_ready(disp_ready),
      .halt(halt)
   );

`ifndef MEM_ACV_EN
   assign acv = 1'b0;
`endif

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      forever begin
         @(posedge clk);
         if (mem_we) mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // One full req/done transaction; lat is the cycle index of done (-1 if never).
   task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d, input bit p,
                         output logic [15:0] rd, output int lat, output int nwe,
                         output logic acv_o, output logic [15:0] ma);
      @(posedge clk); #1;
      req = 1'b1; we = w; addr = a; wdata = d; priv = p;
      lat = -1; nwe = 0; acv_o = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (mem_we) nwe++;
         if (done) begin
            lat = c; acv_o = acv;
            break;
         end
      end
      req = 1'b0; priv = 1'b0;
      rd = rdata; ma = mem_addr;
   endtask

   task automatic kb_press(input logic [7:0] c);
      @(posedge clk); #1;
      kbd_valid = 1'b1; kbd_data = c;
      @(posedge clk); #1;
      kbd_valid = 1'b0;
      if (!kb_full) begin kb_full = 1'b1; kb_char = c; end
   endtask

   task automatic test_reset();
      logic [15:0] rd, ma; int lat, nwe; logic a;
      n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b expected 0", mem_we); else n_pass++;
      n_checks++; if (mem_addr !== 16'h0) $display("FAIL rst_mem_addr: got %h expected 0000", mem_addr); else n_pass++;
      n_checks++; if (mem_wdata !== 16'h0) $display("FAIL rst_mem_wdata: got %h expected 0000", mem_wdata); else n_pass++;
      n_checks++; if (rdata !== 16'h0) $display("FAIL rst_rdata: got %h expected 0000", rdata); else n_pass++;
      n_checks++; if (disp_valid !== 1'b0) $display("FAIL rst_disp_valid: got %b expected 0", disp_valid); else n_pass++;
      n_checks++; if (disp_data !== 8'h0) $display("FAIL rst_disp_data: got %h expected 00", disp_data); else n_pass++;
      n_checks++; if (halt !== 1'b0) $display("FAIL rst_halt: got %b expected 0", halt); else n_pass++;
      n_checks++; if (acv !== 1'b0) $display("FAIL rst_acv: got %b expected 0", acv); else n_pass++;
      access(1'b0, 16'hFE00, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      n_checks++; if (rd !== 16'h0000) $display("FAIL rst_kbsr: got %h expected 0000", rd); else n_pass++;
      access(1'b0, 16'hFFFE, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      n_checks++; if (rd !== 16'h8000) $display("FAIL rst_mcr: got %h expected 8000", rd); else n_pass++;
      n_checks++; if (lat !== 2) $display("FAIL io_latency: got %0d expected 2", lat); else n_pass++;
      last_rd = 16'h8000;
   endtask

   task automatic test_write_read();
      logic [15:0] rd, ma; int lat, nwe; logic a;
      access(1'b1, 16'h0000, 16'h1234, 1'b0, rd, lat, nwe, a, ma);
      ref_mem[16'h0000] = 16'h1234;
      n_checks++; if (lat !== 2) $display("FAIL wr_latency: got %0d expected 2", lat); else n_pass++;
      n_checks++; if (nwe !== 1) $display("FAIL wr_we_cycles: got %0d expected 1", nwe); else n_pass++;
      n_checks++; if (mem[16'h0000] !== 16'h1234) $display("FAIL wr_mem: got %h expected 1234", mem[16'h0000]); else n_pass++;
      n_checks++; if (rd !== last_rd) $display("FAIL wr_rdata_held: got %h expected %h", rd, last_rd); else n_pass++;
      access(1'b0, 16'h0000, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      last_rd = ref_mem[16'h0000];
      n_checks++; if (lat !== READ_LAT + 1) $display("FAIL rd_latency: got %0d expected %0d", lat, READ_LAT + 1); else n_pass++;
      n_checks++; if (nwe !== 0) $display("FAIL rd_we_cycles: got %0d expected 0", nwe); else n_pass++;
      n_checks++; if (rd !== last_rd) $display("FAIL rd_data: got %h expected %h", rd, last_rd); else n_pass++;
      // highest ordinary memory word, just below the device page
      access(1'b1, 16'hFDFF, 16'hA5C3, 1'b0, rd, lat, nwe, a, ma);
      ref_mem[16'hFDFF] = 16'hA5C3;
      n_checks++; if (nwe !== 1) $display("FAIL fdff_we: got %0d expected 1", nwe); else n_pass++;
      access(1'b0, 16'hFDFF, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      last_rd = ref_mem[16'hFDFF];
      n_checks++; if (rd !== last_rd) $display("FAIL fdff_rd: got %h expected %h", rd, last_rd); else n_pass++;
   endtask

   task automatic test_random_mem();
      logic [15:0] rd, ma, a16, d; int lat, nwe, exp_lat; logic a; bit w;
      for (int i = 0; i < 40; i++) begin
         w   = 1'($urandom_range(0, 1));
         a16 = ($urandom_range(0, 3) == 0) ? MMIO_BASE - 16'd1 - 16'($urandom_range(0, 3))
                                           : 16'($urandom_range(0, 63));
         d   = 16'($urandom);
         access(w, a16, d, 1'b0, rd, lat, nwe, a, ma);
         exp_lat = w ? 2 : READ_LAT + 1;
         if (w) ref_mem[a16] = d;
         else   last_rd = ref_mem[a16];
         n_checks++; if (lat !== exp_lat) $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); else n_pass++;
         n_checks++; if (nwe !== int'(w)) $display("FAIL rnd_we[%0d]: got %0d expected %0d", i, nwe, int'(w)); else n_pass++;
         n_checks++; if (rd !== last_rd) $display("FAIL rnd_rdata[%0d]: got %h expected %h", i, rd, last_rd); else n_pass++;
         n_checks++; if (ma !== a16) $display("FAIL rnd_mem_addr[%0d]: got %h expected %h", i, ma, a16); else n_pass++;
      end
      for (int j = 0; j < 64; j++) begin
         if (mem[j] !== ref_mem[j]) begin
            n_checks++; $display("FAIL rnd_mem_image[%0d]: got %h expected %h", j, mem[j], ref_mem[j]);
         end
      end
   endtask

   task automatic test_keyboard();
      logic [15:0] rd, ma, exp; int lat, nwe; logic a;
      kb_press(8'h41);
      kb_press(8'h42);
      access(1'b0, 16'hFE00, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      exp = {kb_full, 15'b0};
      n_checks++; if (rd !== exp) $display("FAIL kbsr_full: got %h expected %h", rd, exp); else n_pass++;
      access(1'b0, 16'hFE02, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      exp = {8'h00, kb_char}; kb_full = 1'b0;
      n_checks++; if (rd !== exp) $display("FAIL kbdr_first: got %h expected %h", rd, exp); else n_pass++;
      access(1'b0, 16'hFE00, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      exp = {kb_full, 15'b0};
      n_checks++; if (rd !== exp) $display("FAIL kbsr_cleared: got %h expected %h", rd, exp); else n_pass++;
      // new character arriving during the KBDR read that clears the flag
      kb_press(8'h43);
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; addr = 16'hFE02;
      @(posedge clk); #1;
      kbd_valid = 1'b1; kbd_data = 8'h44;
      @(posedge clk); #1;
      kbd_valid = 1'b0;
      exp = {8'h00, kb_char};
      n_checks++; if (done !== 1'b1) $display("FAIL kbdr_overlap_done: got %b expected 1", done); else n_pass++;
      n_checks++; if (rdata !== exp) $display("FAIL kbdr_overlap_rd: got %h expected %h", rdata, exp); else n_pass++;
      req = 1'b0;
      kb_full = 1'b1; kb_char = 8'h44;
      access(1'b0, 16'hFE00, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      n_checks++; if (rd !== 16'h8000) $display("FAIL kbsr_overlap: got %h expected 8000", rd); else n_pass++;
      access(1'b0, 16'hFE02, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      exp = {8'h00, kb_char}; kb_full = 1'b0; last_rd = exp;
      n_checks++; if (rd !== exp) $display("FAIL kbdr_overlap_char: got %h expected %h", rd, exp); else n_pass++;
   endtask

   task automatic test_display();
      logic [15:0] rd, ma; int lat, nwe; logic a;
      disp_ready = 1'b0;
      access(1'b1, 16'hFE06, 16'h0058, 1'b0, rd, lat, nwe, a, ma);
      n_checks++; if (nwe !== 0) $display("FAIL ddr_no_mem_we: got %0d expected 0", nwe); else n_pass++;
      n_checks++; if (disp_data !== 8'h58) $display("FAIL ddr_data: got %h expected 58", disp_data); else n_pass++;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_checks++; if (disp_valid !== 1'b1) $display("FAIL ddr_pending[%0d]: got %b expected 1", c, disp_valid); else n_pass++;
      end
      access(1'b0, 16'hFE04, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      n_checks++; if (rd !== 16'h0000) $display("FAIL dsr_busy: got %h expected 0000", rd); else n_pass++;
      access(1'b1, 16'hFE06, 16'h0062, 1'b0, rd, lat, nwe, a, ma);
      n_checks++; if (disp_valid !== 1'b1 || disp_data !== 8'h62)
         $display("FAIL ddr_overwrite: got %b/%h expected 1/62", disp_valid, disp_data); else n_pass++;
      @(posedge clk); #1; disp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (disp_valid !== 1'b0) $display("FAIL ddr_accepted: got %b expected 0", disp_valid); else n_pass++;
      access(1'b0, 16'hFE04, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      last_rd = 16'h8000;
      n_checks++; if (rd !== 16'h8000) $display("FAIL dsr_ready: got %h expected 8000", rd); else n_pass++;
   endtask

   task automatic test_mcr();
      logic [15:0] rd, ma; int lat, nwe; logic a;
      access(1'b1, 16'hFFFE, 16'h0000, 1'b0, rd, lat, nwe, a, ma);
      n_checks++; if (halt !== 1'b1) $display("FAIL mcr_halt: got %b expected 1", halt); else n_pass++;
      n_checks++; if (nwe !== 0) $display("FAIL mcr_no_mem_we: got %0d expected 0", nwe); else n_pass++;
      n_checks++; if (mem[16'hFFFE] !== ref_mem[16'hFFFE]) $display("FAIL mcr_mem_untouched: got %h expected %h", mem[16'hFFFE], ref_mem[16'hFFFE]); else n_pass++;
      access(1'b0, 16'hFFFE, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      last_rd = 16'h0000;
      n_checks++; if (rd !== 16'h0000) $display("FAIL mcr_read: got %h expected 0000", rd); else n_pass++;
      access(1'b1, 16'hFFFE, 16'h8000, 1'b0, rd, lat, nwe, a, ma);
      n_checks++; if (halt !== 1'b0) $display("FAIL mcr_run: got %b expected 0", halt); else n_pass++;
      access(1'b1, 16'hFE10, 16'h7777, 1'b0, rd, lat, nwe, a, ma);
      n_checks++; if (nwe !== 0) $display("FAIL unmapped_wr: got %0d expected 0", nwe); else n_pass++;
      access(1'b0, 16'hFE10, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      last_rd = 16'h0000;
      n_checks++; if (rd !== 16'h0000) $display("FAIL unmapped_rd: got %h expected 0000", rd); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] rd, ma; int lat, nwe, n_done, n_we; logic a;
      @(posedge clk); #1;
      req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'hBEEF;
      n_done = 0; n_we = 0;
      repeat (9) begin
         @(posedge clk); #1;
         if (done) n_done++;
         if (mem_we) n_we++;
      end
      req = 1'b0;
      ref_mem[16'h0010] = 16'hBEEF;
      n_checks++; if (n_done !== 3) $display("FAIL b2b_done_count: got %0d expected 3", n_done); else n_pass++;
      n_checks++; if (n_we !== 3) $display("FAIL b2b_we_count: got %0d expected 3", n_we); else n_pass++;
      access(1'b0, 16'h0010, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      last_rd = ref_mem[16'h0010];
      n_checks++; if (rd !== last_rd) $display("FAIL b2b_data: got %h expected %h", rd, last_rd); else n_pass++;
   endtask

   task automatic test_reset_midop();
      logic [15:0] rd, ma; int lat, nwe; logic a; bit saw_done;
      access(1'b1, 16'h0005, 16'h1111, 1'b0, rd, lat, nwe, a, ma);
      ref_mem[16'h0005] = 16'h1111;
      @(posedge clk); #1;
      req = 1'b1; we = 1'b1; addr = 16'h0005; wdata = 16'h2222;
      @(posedge clk); #1;
      n_checks++; if (mem_we !== 1'b1) $display("FAIL midop_we_before: got %b expected 1", mem_we); else n_pass++;
      rst_n = 1'b0; #1;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL midop_we_reset: got %b expected 0", mem_we); else n_pass++;
      req = 1'b0;
      @(posedge clk); @(negedge clk); rst_n = 1'b1;
      kb_full = 1'b0; last_rd = 16'h0000;
      saw_done = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      n_checks++; if (saw_done) $display("FAIL midop_late_done: got 1 expected 0"); else n_pass++;
      n_checks++; if (mem[16'h0005] !== ref_mem[16'h0005]) $display("FAIL midop_late_write: got %h expected %h", mem[16'h0005], ref_mem[16'h0005]); else n_pass++;
      access(1'b0, 16'h0005, 16'h0, 1'b0, rd, lat, nwe, a, ma);
      last_rd = ref_mem[16'h0005];
      n_checks++; if (rd !== last_rd) $display("FAIL midop_old_value: got %h expected %h", rd, last_rd); else n_pass++;
   endtask

   task automatic test_priv();
      logic [15:0] rd, ma, ma0; int lat, nwe; logic a;
`ifdef MEM_ACV_EN
      ma0 = mem_addr;
      access(1'b0, 16'h0200, 16'h0, 1'b1, rd, lat, nwe, a, ma);
      n_checks++; if (lat !== 1) $display("FAIL acv_latency: got %0d expected 1", lat); else n_pass++;
      n_checks++; if (a !== 1'b1) $display("FAIL acv_flag: got %b expected 1", a); else n_pass++;
      n_checks++; if (ma !== ma0) $display("FAIL acv_mem_addr: got %h expected %h", ma, ma0); else n_pass++;
      n_checks++; if (rd !== last_rd) $display("FAIL acv_rdata: got %h expected %h", rd, last_rd); else n_pass++;
      access(1'b1, 16'h0100, 16'hDEAD, 1'b1, rd, lat, nwe, a, ma);
      n_checks++; if (nwe !== 0 || a !== 1'b1) $display("FAIL acv_write: got we=%0d acv=%b expected 0/1", nwe, a); else n_pass++;
      access(1'b1, 16'h3000, 16'h5A5A, 1'b0, rd, lat, nwe, a, ma);
      ref_mem[16'h3000] = 16'h5A5A;
      access(1'b0, 16'h3000, 16'h0, 1'b1, rd, lat, nwe, a, ma);
      last_rd = ref_mem[16'h3000];
      n_checks++; if (lat !== READ_LAT + 1 || a !== 1'b0)
         $display("FAIL user_ok: got lat=%0d acv=%b expected %0d/0", lat, a, READ_LAT + 1); else n_pass++;
      n_checks++; if (rd !== last_rd) $display("FAIL user_ok_data: got %h expected %h", rd, last_rd); else n_pass++;
`else
      ma0 = 16'h0200;
      access(1'b1, 16'h0200, 16'h6B6B, 1'b1, rd, lat, nwe, a, ma);
      ref_mem[16'h0200] = 16'h6B6B;
      access(1'b0, 16'h0200, 16'h0, 1'b1, rd, lat, nwe, a, ma);
      last_rd = ref_mem[16'h0200];
      n_checks++; if (lat !== READ_LAT + 1) $display("FAIL priv_ignored_lat: got %0d expected %0d", lat, READ_LAT + 1); else n_pass++;
      n_checks++; if (rd !== last_rd) $display("FAIL priv_ignored_data: got %h expected %h", rd, last_rd); else n_pass++;
      n_checks++; if (ma !== ma0) $display("FAIL priv_ignored_addr: got %h expected %h", ma, ma0); else n_pass++;
`endif
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = 16'h0000;
      last_rd = 16'h0000; kb_full = 1'b0; kb_char = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      #1;
      test_reset();
      test_write_read();
      test_random_mem();
      test_keyboard();
      test_display();
      test_mcr();
      test_back_to_back();
      test_reset_midop();
      test_priv();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
